// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port instruction/data memory between the fetch stage and
// the load/store unit. In IDLE both requests are sampled, one winner is
// picked, and its address, write data and write enable are latched onto the
// memory port. mem_en is then held for WAIT_CYCLES cycles. At the last access
// edge the winner receives a one-cycle valid pulse and, for reads, its rdata
// register is loaded from mem_rdata.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, data wins a tie against fetch.
//   defined   : a last_served flag (reset = fetch) alternates ties; the
//               first tie goes to data.
//
// Parameters
//   ADDR_W       word address width
//   DATA_W       data width
//   WAIT_CYCLES  cycles mem_en is held per access (1..15)
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   if_req, if_addr             fetch request and address (held until if_gnt)
//   if_gnt, if_valid            fetch accept pulse / fetch data-ready pulse
//   if_rdata                    fetched instruction, held until next if_valid
//   d_req, d_we, d_addr, d_wdata  data request (held until d_gnt)
//   d_gnt, d_valid              data accept pulse / access-complete pulse
//   d_rdata                     load data, updated on reads only
//   mem_en, mem_we              memory enable / write enable
//   mem_addr, mem_wdata         latched memory address / write data
//   mem_rdata                   memory read data, valid in last access cycle
//   busy                        high while an access is in progress
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] ACCESS   = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [0:0] state_r;
    logic [3:0] cnt_r;
    logic       win_d_r;     // 1 = current access belongs to the data port
    logic       any_req_s;
    logic       pick_d_s;    // 1 = data port wins this arbitration

    assign any_req_s = if_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_r;          // 1 = data was served last, 0 = fetch

    // Winner selection: on a tie, the requester not served last wins.
    always_comb begin
        pick_d_s = d_req;
        if (d_req && if_req) begin
            pick_d_s = ~last_d_r;
        end else begin
            pick_d_s = d_req;
        end
    end

    // Remember which requester received the most recent grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d_r <= 1'b0;
        end else if ((state_r == IDLE) && any_req_s) begin
            last_d_r <= pick_d_s;
        end else begin
            last_d_r <= last_d_r;
        end
    end
`else
    // Winner selection: data always beats fetch on a tie.
    always_comb begin
        pick_d_s = d_req;
    end
`endif

    // Arbitration FSM, memory-port latches and requester handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            win_d_r   <= 1'b0;
            if_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            if_rdata  <= {DATA_W{1'b0}};
            d_gnt     <= 1'b0;
            d_valid   <= 1'b0;
            d_rdata   <= {DATA_W{1'b0}};
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            busy      <= 1'b0;
        end else begin
            // Handshake pulses last exactly one cycle.
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        win_d_r   <= pick_d_s;
                        mem_addr  <= pick_d_s ? d_addr : if_addr;
                        mem_wdata <= pick_d_s ? d_wdata : {DATA_W{1'b0}};
                        mem_we    <= pick_d_s & d_we;
                        mem_en    <= 1'b1;
                        cnt_r     <= CNT_INIT;
                        if_gnt    <= ~pick_d_s;
                        d_gnt     <= pick_d_s;
                        busy      <= 1'b1;
                        state_r   <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        // mem_we still holds the latched direction here.
                        if (win_d_r) begin
                            d_valid <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                d_rdata <= d_rdata;
                            end
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
